load_store_stage: RTL

//  Memory-access stage directly downstream of the ALU: consumes the ALU result as

---
 rtl/load_store_stage.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/load_store_stage.sv
// load_store_stage: memory stage after the ALU, one outstanding dmem req/ack, byte lanes and load extension; define MISALIGN_TRAP_EN to trap misaligned H/W accesses.
// Latency: non-mem writeback 1 cycle after accept, mem ops 1 cycle after dmem_ack (min 2); ex_ready is low while a request is outstanding.
module load_store_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            flush,
  input  logic            is_load,
  input  logic            is_store,
  input  logic [2:0]      mem_funct3,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] store_data,
  input  logic [4:0]      rd_addr,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            misalign_exc,
  output logic [XLEN-1:0] exc_addr
);

  typedef enum logic {IDLE, REQ} state_t;

  typedef struct packed {
    logic       load;
    logic       kill;
    logic [2:0] funct3;
    logic [1:0] off;
    logic [4:0] rd;
  } pend_t;

  state_t          state_q, state_d;
  pend_t           pend_q;
  logic            active_q;
  logic            accept, is_mem, misaligned;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata, ld_data;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  // active_q keeps ex_ready low through reset and releases it the cycle after.
  assign ex_ready = active_q && (state_q == IDLE);
  assign is_mem   = is_load | is_store;
  assign accept   = ex_valid & ex_ready & ~flush;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = is_mem &
                      (((mem_funct3[1:0] == 2'b01) & alu_result[0]) |
                       ((mem_funct3[1:0] == 2'b10) & (|alu_result[1:0])));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = store_data;
    if (is_load) begin
      st_wdata = '0;
    end else begin
      unique case (mem_funct3[1:0])
        2'b00: begin
          st_be    = 4'b0001 << alu_result[1:0];
          st_wdata = {4{store_data[7:0]}};
        end
        2'b01: begin
          st_be    = 4'b0011 << {alu_result[1], 1'b0};
          st_wdata = {2{store_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ld_byte = dmem_rdata[{pend_q.off, 3'b000} +: 8];
    ld_half = dmem_rdata[{pend_q.off[1], 4'b0000} +: 16];
    unique case (pend_q.funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'b0, ld_byte};
      3'b101:  ld_data = {16'b0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && is_mem && !misaligned) state_d = REQ;
      REQ:     if (dmem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q   <= 1'b0;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      pend_q     <= '0;
    end else begin
      active_q <= 1'b1;
      wb_valid <= 1'b0;
      if (accept && !misaligned) begin
        if (is_mem) begin
          dmem_req   <= 1'b1;
          dmem_we    <= is_store;
          dmem_addr  <= {alu_result[XLEN-1:2], 2'b00};
          dmem_be    <= st_be;
          dmem_wdata <= st_wdata;
          pend_q     <= '{load: is_load, kill: 1'b0, funct3: mem_funct3,
                          off: alu_result[1:0], rd: rd_addr};
        end else begin
          wb_valid <= 1'b1;
          wb_we    <= |rd_addr;
          wb_rd    <= rd_addr;
          wb_data  <= alu_result;
        end
      end else if (state_q == REQ) begin
        // A flushed request still completes on the bus; only its writeback is dropped.
        if (flush) pend_q.kill <= 1'b1;
        if (dmem_ack) begin
          dmem_req <= 1'b0;
          if (!(pend_q.kill || flush)) begin
            wb_valid <= 1'b1;
            wb_we    <= pend_q.load & (|pend_q.rd);
            wb_rd    <= pend_q.rd;
            if (pend_q.load) wb_data <= ld_data;
          end
        end
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic            exc_q;
  logic [XLEN-1:0] exc_addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      exc_q      <= 1'b0;
      exc_addr_q <= '0;
    end else begin
      exc_q <= accept & misaligned;
      if (accept && misaligned) exc_addr_q <= alu_result;
    end
  end

  assign misalign_exc = exc_q;
  assign exc_addr     = exc_addr_q;
`else
  assign misalign_exc = 1'b0;
  assign exc_addr     = '0;
`endif

endmodule
